// File: rtl/updown_counter_mod.sv
// updown_counter_mod: parametrised up/down binary counter with modulus, wrap or
// saturate behaviour at the range limits, terminal count, boundary pulse and
// sticky overflow/underflow flags.
//
// Parameters:
//   WIDTH    - counter and load-data width in bits (2..32)
//   MODULUS  - count range is 0..MODULUS-1 (2..2**WIDTH)
//   SATURATE - 0: wrap at the limits, 1: hold at the limits
//
// Ports:
//   clk     - rising-edge clock
//   reset   - asynchronous active-low reset
//   clear   - synchronous clear of count and flags (highest priority)
//   load    - synchronous parallel load of in (clamped to MODULUS-1)
//   in      - load data
//   en      - count enable
//   up_down - direction, 0 = up, 1 = down
//   count   - registered counter value
//   tc      - combinational terminal count: next edge is a boundary event
//   wrap    - registered one-cycle pulse following each boundary event
//   ovf     - sticky, an up-count hit the upper limit
//   unf     - sticky, a down-count hit the lower limit
module updown_counter_mod #(
   parameter int unsigned     WIDTH    = 8,
   parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
   parameter bit              SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] in,
   input  logic             en,
   input  logic             up_down,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap,
   output logic             ovf,
   output logic             unf
);

   localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 64'd1);

   logic [WIDTH-1:0] r_count;
   logic             r_wrap;
   logic             r_ovf;
   logic             r_unf;

   logic [WIDTH-1:0] w_count_nxt;
   logic             w_at_max;
   logic             w_at_min;
   logic             w_bnd;

   assign w_at_max = (r_count == MaxVal);
   assign w_at_min = (r_count == '0);

   // Boundary event on the coming edge; clear and load suppress counting.
   assign w_bnd = en & ~load & ~clear & (up_down ? w_at_min : w_at_max);

   always_comb begin
      w_count_nxt = r_count;
      if (clear) begin
         w_count_nxt = '0;
      end else if (load) begin
         w_count_nxt = (in > MaxVal) ? MaxVal : in;
      end else if (en) begin
         if (!up_down) begin
            if (w_at_max) w_count_nxt = SATURATE ? MaxVal : '0;
            else          w_count_nxt = r_count + WIDTH'(1);
         end else begin
            if (w_at_min) w_count_nxt = SATURATE ? '0 : MaxVal;
            else          w_count_nxt = r_count - WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
         r_wrap  <= 1'b0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else begin
         r_count <= w_count_nxt;
         r_wrap  <= w_bnd;
         r_ovf   <= ~clear & (r_ovf | (w_bnd & ~up_down));
         r_unf   <= ~clear & (r_unf | (w_bnd & up_down));
      end
   end

   assign count = r_count;
   assign tc    = w_bnd;
   assign wrap  = r_wrap;
   assign ovf   = r_ovf;
   assign unf   = r_unf;

endmodule

// File: tb/tb_updown_counter_mod.sv
module tb_updown_counter_mod;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       clear = 1'b0;
   logic       load = 1'b0;
   logic [7:0] in = '0;
   logic       en = 1'b0;
   logic       up_down = 1'b0;

   logic [7:0] cnt_a, cnt_b;
   logic [3:0] cnt_c;
   logic [2:0] tc_v, wrap_v, ovf_v, unf_v;

   always #5 clk = ~clk;

   // A: MODULUS=200 wrap, B: MODULUS=200 saturate, C: WIDTH=4 full range.
   updown_counter_mod #(.WIDTH(8), .MODULUS(200), .SATURATE(1'b0)) u_a (
      .clk(clk), .reset(reset), .clear(clear), .load(load), .in(in), .en(en),
      .up_down(up_down), .count(cnt_a), .tc(tc_v[0]), .wrap(wrap_v[0]),
      .ovf(ovf_v[0]), .unf(unf_v[0])
   );
   updown_counter_mod #(.WIDTH(8), .MODULUS(200), .SATURATE(1'b1)) u_b (
      .clk(clk), .reset(reset), .clear(clear), .load(load), .in(in), .en(en),
      .up_down(up_down), .count(cnt_b), .tc(tc_v[1]), .wrap(wrap_v[1]),
      .ovf(ovf_v[1]), .unf(unf_v[1])
   );
   updown_counter_mod #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_c (
      .clk(clk), .reset(reset), .clear(clear), .load(load), .in(in[3:0]), .en(en),
      .up_down(up_down), .count(cnt_c), .tc(tc_v[2]), .wrap(wrap_v[2]),
      .ovf(ovf_v[2]), .unf(unf_v[2])
   );

   typedef struct {
      int         dut;
      logic [7:0] cnt;
      logic       tc;
      logic       wrap;
      logic       ovf;
      logic       unf;
      string      name;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   function automatic logic [7:0] dut_cnt(int d);
      case (d)
         0:       return cnt_a;
         1:       return cnt_b;
         default: return {4'b0, cnt_c};
      endcase
   endfunction

   task automatic compare(input exp_t e);
      logic [7:0] c;
      c = dut_cnt(e.dut);
      checks++;
      if (c !== e.cnt || tc_v[e.dut] !== e.tc || wrap_v[e.dut] !== e.wrap ||
          ovf_v[e.dut] !== e.ovf || unf_v[e.dut] !== e.unf) begin
         errors++;
         $display("FAIL %s dut%0d: got cnt=%0d tc=%b wrap=%b ovf=%b unf=%b, want cnt=%0d tc=%b wrap=%b ovf=%b unf=%b",
                  e.name, e.dut, c, tc_v[e.dut], wrap_v[e.dut], ovf_v[e.dut], unf_v[e.dut],
                  e.cnt, e.tc, e.wrap, e.ovf, e.unf);
      end
   endtask

   // Monitor: each edge after stimulus the DUT presents a new state; pop and compare.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) compare(q.pop_front());
      end
   end

   // Drive one cycle of inputs and queue the expected post-edge state.
   task automatic step(input int d, input string nm, input logic c_i, input logic l_i,
                       input logic [7:0] in_i, input logic en_i, input logic ud_i,
                       input logic [7:0] e_cnt, input logic e_tc, input logic e_wrap,
                       input logic e_ovf, input logic e_unf);
      exp_t e;
      @(negedge clk);
      clear = c_i; load = l_i; in = in_i; en = en_i; up_down = ud_i;
      e.dut = d; e.name = nm; e.cnt = e_cnt; e.tc = e_tc; e.wrap = e_wrap;
      e.ovf = e_ovf; e.unf = e_unf;
      q.push_back(e);
   endtask

   task automatic direct(input string nm, input int d, input logic [7:0] e_cnt);
      exp_t e;
      e.dut = d; e.name = nm; e.cnt = e_cnt; e.tc = 1'b0; e.wrap = 1'b0;
      e.ovf = 1'b0; e.unf = 1'b0;
      compare(e);
   endtask

   initial begin
      #12;
      for (int d = 0; d < 3; d++) direct("reset_state", d, 8'd0);
      @(negedge clk);
      reset = 1'b1;

      // A: async reset mid-count, up wrap, down wrap, direction change, priority.
      //     dut name          clr ld  in     en  ud  cnt    tc  wr  ov  un
      step(0, "a_load56",     0,  1,  8'd56, 0,  0,  8'd56,  0,  0,  0,  0);
      step(0, "a_up57",       0,  0,  8'd0,  1,  0,  8'd57,  0,  0,  0,  0);
      @(posedge clk);
      #3;
      reset = 1'b0;
      clear = 0; load = 0; in = '0; en = 0; up_down = 0;
      #1;
      direct("a_async_reset", 0, 8'd0);
      @(negedge clk);
      reset = 1'b1;
      step(0, "a_resume",     0,  0,  8'd0,  1,  0,  8'd1,   0,  0,  0,  0);
      step(0, "a_load198",    0,  1,  8'd198,0,  0,  8'd198, 0,  0,  0,  0);
      step(0, "a_up199_tc",   0,  0,  8'd0,  1,  0,  8'd199, 1,  0,  0,  0);
      step(0, "a_up_wrap0",   0,  0,  8'd0,  1,  0,  8'd0,   0,  1,  1,  0);
      step(0, "a_up1",        0,  0,  8'd0,  1,  0,  8'd1,   0,  0,  1,  0);
      step(0, "a_load1",      0,  1,  8'd1,  0,  1,  8'd1,   0,  0,  1,  0);
      step(0, "a_dn0_tc",     0,  0,  8'd0,  1,  1,  8'd0,   1,  0,  1,  0);
      step(0, "a_dn_wrap199", 0,  0,  8'd0,  1,  1,  8'd199, 0,  1,  1,  1);
      step(0, "a_dirchg_up0", 0,  0,  8'd0,  1,  0,  8'd0,   0,  1,  1,  1);
      step(0, "a_en0_ud1",    0,  0,  8'd0,  0,  1,  8'd0,   0,  0,  1,  1);
      step(0, "a_en0_ud0",    0,  0,  8'd0,  0,  0,  8'd0,   0,  0,  1,  1);
      step(0, "a_clamp250",   0,  1,  8'd250,1,  0,  8'd199, 0,  0,  1,  1);
      step(0, "a_clear_prio", 1,  1,  8'd10, 1,  0,  8'd0,   0,  0,  0,  0);

      // B: saturate mode (state was cleared by the previous step).
      step(1, "b_load199",    0,  1,  8'd199,0,  0,  8'd199, 0,  0,  0,  0);
      step(1, "b_sat_up1",    0,  0,  8'd0,  1,  0,  8'd199, 1,  1,  1,  0);
      step(1, "b_sat_up2",    0,  0,  8'd0,  1,  0,  8'd199, 1,  1,  1,  0);
      step(1, "b_sat_up3",    0,  0,  8'd0,  1,  0,  8'd199, 1,  1,  1,  0);
      step(1, "b_load0",      0,  1,  8'd0,  0,  0,  8'd0,   0,  0,  1,  0);
      step(1, "b_sat_dn",     0,  0,  8'd0,  1,  1,  8'd0,   1,  1,  1,  1);
      step(1, "b_idle",       0,  0,  8'd0,  0,  1,  8'd0,   0,  0,  1,  1);
      step(1, "b_clear",      1,  0,  8'd0,  0,  0,  8'd0,   0,  0,  0,  0);

      // C: 4-bit full-range roll-over.
      step(2, "c_load15",     0,  1,  8'd15, 0,  0,  8'd15,  0,  0,  0,  0);
      step(2, "c_roll_up",    0,  0,  8'd0,  1,  0,  8'd0,   0,  1,  1,  0);
      step(2, "c_roll_dn",    0,  0,  8'd0,  1,  1,  8'd15,  0,  1,  1,  1);
      step(2, "c_idle",       0,  0,  8'd0,  0,  0,  8'd15,  0,  0,  1,  1);

      for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
      #2;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected responses never checked, want 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
